// File: rtl/mem_access.sv
// mem_access: memory-access (M) pipeline stage.
// Holds the EX/M register, drives the data-memory req/ready/rvalid handshake
// and stalls the pipeline while a load or store is outstanding.
// Optional feature: define MEM_TIMEOUT_EN to enable a REQ/WAIT watchdog that
// sets the sticky mem_error flag after TIMEOUT_CYCLES and releases the stall.
module mem_access #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_m,
  input  logic [XLEN-1:0] alu_result_e,
  input  logic [XLEN-1:0] pc_plus4_e,
  input  logic [XLEN-1:0] rd1_e,
  input  logic [XLEN-1:0] imm_ext_e,
  input  logic [XLEN-1:0] fpu_rd1_e,
  input  logic [XLEN-1:0] fpu_result_e,
  input  logic [XLEN-1:0] data_addr_e,
  input  logic [XLEN-1:0] write_data_e,
  input  logic [4:0]      rd_e,
  input  logic [2:0]      result_src_e,
  input  logic            reg_write_e,
  input  logic            fpu_reg_write_e,
  input  logic            mem_write_e,
  input  logic            mem_read_e,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] pc_plus4_m,
  output logic [XLEN-1:0] rd1_m,
  output logic [XLEN-1:0] imm_ext_m,
  output logic [XLEN-1:0] fpu_rd1_m,
  output logic [XLEN-1:0] fpu_result_m,
  output logic [4:0]      rd_m,
  output logic [2:0]      result_src_m,
  output logic            reg_write_m,
  output logic            fpu_reg_write_m,
  output logic [XLEN-1:0] read_data_m,
  output logic            stall_m,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_error
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e          state_q;
  logic [XLEN-1:0] data_addr_q;
  logic [XLEN-1:0] write_data_q;
  logic            mem_write_q;
  logic            mem_read_q;
  logic            done_q;
  logic            mem_op;
  logic            is_store;
  logic            capture;

  assign mem_op   = mem_read_q | mem_write_q;
  // Read and write both set is illegal and handled as a load.
  assign is_store = mem_write_q & ~mem_read_q;
  assign capture  = ~stall_m;

  // Request and stall are combinational so a ready store costs no stall cycle.
  always_comb begin
    dmem_req = 1'b0;
    stall_m  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        dmem_req = mem_op & ~done_q;
        stall_m  = mem_op & ~done_q & ~(dmem_ready & is_store);
      end
      S_REQ: begin
        dmem_req = 1'b1;
        stall_m  = 1'b1;
      end
      S_WAIT:  stall_m = 1'b1;
      S_DONE:  stall_m = 1'b0;
      default: stall_m = 1'b0;
    endcase
  end

  assign dmem_we    = dmem_req & is_store;
  assign dmem_addr  = data_addr_q;
  assign dmem_wdata = write_data_q;

  // EX/M register: capture when not stalled, bubble on flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_result_m    <= '0;
      pc_plus4_m      <= '0;
      rd1_m           <= '0;
      imm_ext_m       <= '0;
      fpu_rd1_m       <= '0;
      fpu_result_m    <= '0;
      rd_m            <= '0;
      result_src_m    <= '0;
      reg_write_m     <= 1'b0;
      fpu_reg_write_m <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      data_addr_q     <= '0;
      write_data_q    <= '0;
    end else if (capture) begin
      alu_result_m    <= alu_result_e;
      pc_plus4_m      <= pc_plus4_e;
      rd1_m           <= rd1_e;
      imm_ext_m       <= imm_ext_e;
      fpu_rd1_m       <= fpu_rd1_e;
      fpu_result_m    <= fpu_result_e;
      rd_m            <= rd_e;
      result_src_m    <= result_src_e;
      data_addr_q     <= data_addr_e;
      write_data_q    <= write_data_e;
      reg_write_m     <= reg_write_e & ~flush_m;
      fpu_reg_write_m <= fpu_reg_write_e & ~flush_m;
      mem_write_q     <= mem_write_e & ~flush_m;
      mem_read_q      <= mem_read_e & ~flush_m;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;
  logic            mem_error_q;
  logic            timeout_hit;
  assign timeout_hit = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign mem_error   = mem_error_q;
`else
  assign mem_error = 1'b0;
`endif

  // Handshake FSM, completion flag and load-data capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      done_q      <= 1'b0;
      read_data_m <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
      mem_error_q <= 1'b0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      if (state_q == S_REQ || state_q == S_WAIT) cnt_q <= cnt_q + 1'b1;
      else                                       cnt_q <= '0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (mem_op && !done_q) begin
            if (dmem_ready) begin
              if (is_store) done_q  <= 1'b1;
              else          state_q <= S_WAIT;
            end else begin
              state_q <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dmem_ready) begin
            state_q <= is_store ? S_DONE : S_WAIT;
            if (is_store) done_q <= 1'b1;
          end
`ifdef MEM_TIMEOUT_EN
          else if (timeout_hit) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            mem_error_q <= 1'b1;
            if (!is_store) read_data_m <= XLEN'(32'hDEADBEEF);
          end
`endif
        end
        S_WAIT: begin
          if (dmem_rvalid) begin
            read_data_m <= dmem_rdata;
            state_q     <= S_DONE;
            done_q      <= 1'b1;
          end
`ifdef MEM_TIMEOUT_EN
          else if (timeout_hit) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            mem_error_q <= 1'b1;
            read_data_m <= XLEN'(32'hDEADBEEF);
          end
`endif
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      // A newly captured instruction always starts uncompleted; this overrides
      // the set above on the zero-stall store edge.
      if (capture) done_q <= 1'b0;
    end
  end

endmodule
